record_play_sequencer: RTL and testbench

- Top-level sequencer for the Nexys4 audio recorder. Owns record/playback mode, the sample-rate strobe and the sample-memory address.
- Record: writes one sample per strobe into sample memory until a stop request or until memory is full.
- Play: reads back exactly the recorded length, then returns to idle.
- Sits between debounced button pulses and the sample BRAM/PWM path. Replaces ad-hoc fixed-duration timing with a length-tracked recording.

---
 rtl/recorder_pkg.sv | 16 +
 rtl/record_play_sequencer_strobe.sv | 40 ++++
 rtl/record_play_sequencer.sv | 153 +++++++++++++++
 tb/tb_record_play_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/recorder_pkg.sv
// Shared types and default clocking constants for the audio recorder.
package recorder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } rec_state_t;

  localparam int CLK_HZ    = 100_000_000;
  localparam int SAMPLE_HZ = 48_000;

  // Integer division gives 2083 cycles per sample at the defaults.
  localparam int DEFAULT_SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;

endpackage

// File: rtl/record_play_sequencer_strobe.sv
// Sample-rate strobe: free-running divider that runs only while enabled.
// The count is held at zero whenever enable is low, so every enable period
// starts fresh and the first tick lands DIV-1 cycles after enable rises.
module sample_strobe #(
  parameter int DIV = 2083
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear when disabled or on wrap, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Divider register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/record_play_sequencer.sv
// Record/playback sequencer: owns the mode FSM, the write/read pointers,
// the recorded length and the registered sample-memory strobes.
module record_play_sequencer
  import recorder_pkg::*;
#(
  parameter int SAMPLE_DIV  = DEFAULT_SAMPLE_DIV,
  parameter int ADDR_W      = 17,
  parameter int MAX_SAMPLES = 96000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              record_req,
  input  logic              play_req,
  input  logic              stop_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W:0]   rec_len,
  output logic              recording,
  output logic              playing,
  output logic              done
);

  // Lengths and pointers carry one extra bit so a full 2**ADDR_W memory
  // is representable and all compares stay unsigned and same-width.
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_SAMPLES);

  rec_state_t       state_q, state_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] rec_len_q, rec_len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic             done_q, done_d;

  logic [LEN_W-1:0] wr_next;
  logic [LEN_W-1:0] rd_next;
  logic             strobe_en;
  logic             tick;

  assign strobe_en = (state_q == REC) || (state_q == PLAY);
  assign wr_next   = wr_ptr_q + LEN_W'(1);
  assign rd_next   = rd_ptr_q + LEN_W'(1);

  sample_strobe #(
    .DIV (SAMPLE_DIV)
  ) u_strobe (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (strobe_en),
    .tick    (tick)
  );

  // Mode transitions, pointer updates and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rec_len_d = rec_len_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // A stop in IDLE is a no-op but still blocks lower-priority requests.
        if (!stop_req) begin
          if (record_req) begin
            state_d   = REC;
            wr_ptr_d  = '0;
            // The old take is being overwritten, so it is no longer valid.
            rec_len_d = '0;
          end else if (play_req && (rec_len_q != '0)) begin
            state_d  = PLAY;
            rd_ptr_d = '0;
          end
        end
      end

      REC: begin
        if (stop_req) begin
          // A tick coinciding with the stop is dropped; keep what was written.
          rec_len_d = wr_ptr_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (tick) begin
          we_d     = 1'b1;
          addr_d   = wr_ptr_q[ADDR_W-1:0];
          wr_ptr_d = wr_next;
          if (wr_next == MAX_LEN) begin
            rec_len_d = MAX_LEN;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      PLAY: begin
        if (stop_req) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tick) begin
          re_d     = 1'b1;
          addr_d   = rd_ptr_q[ADDR_W-1:0];
          rd_ptr_d = rd_next;
          if (rd_next == rec_len_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer and output registers; reset also discards the recording.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rec_len_q <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rec_len_q <= rec_len_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      re_q      <= re_d;
      done_q    <= done_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign rec_len   = rec_len_q;
  assign recording = (state_q == REC);
  assign playing   = (state_q == PLAY);
  assign done      = done_q;

endmodule

// File: tb/tb_record_play_sequencer.sv
// Bench for record_play_sequencer with SAMPLE_DIV=4, ADDR_W=3, MAX_SAMPLES=8.
`timescale 1ns/1ps
module tb_record_play_sequencer;

  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          record_req = 1'b0;
  logic          play_req = 1'b0;
  logic          stop_req = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic          mem_re;
  logic [AW:0]   rec_len;
  logic          recording;
  logic          playing;
  logic          done;

  record_play_sequencer #(
    .SAMPLE_DIV  (4),
    .ADDR_W      (AW),
    .MAX_SAMPLES (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .record_req (record_req),
    .play_req   (play_req),
    .stop_req   (stop_req),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .rec_len    (rec_len),
    .recording  (recording),
    .playing    (playing),
    .done       (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit is_write;
    int addr;
  } sb_t;

  typedef struct {
    int stop_after;  // writes seen before stop_req; -1 = run to memory full
    int exp_len;     // expected rec_len and expected playback reads
  } vec_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
  endfunction

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic push_seq(input bit w, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back('{w, i});
  endtask

  // Scoreboard: every memory strobe must match the next expected access.
  always @(negedge clock) begin
    sb_t e;
    if (mem_we || mem_re) begin
      check("we_re_exclusive", int'(mem_we && mem_re), 0);
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("strobe_kind", int'(mem_we), int'(e.is_write));
        check("strobe_addr", int'(mem_addr), e.addr);
      end
    end
    if (done) check("done_exclusive", int'(recording || playing), 0);
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got 1, wanted 0");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs[5];
    int   t, nwe, nre, extra;

    vecs[0] = '{-1, 8};
    vecs[1] = '{3, 3};
    vecs[2] = '{0, 0};
    vecs[3] = '{5, 5};
    vecs[4] = '{1, 1};

    // Reset state
    reset_n = 1'b0;
    step; step;
    check("rst_addr", int'(mem_addr), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_re", int'(mem_re), 0);
    check("rst_rec_len", int'(rec_len), 0);
    check("rst_recording", int'(recording), 0);
    check("rst_playing", int'(playing), 0);
    check("rst_done", int'(done), 0);
    reset_n = 1'b1;
    step;

    // Empty play is ignored
    play_req = 1'b1; step; play_req = 1'b0;
    check("empty_play_playing", int'(playing), 0);
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      step;
      extra += int'(mem_re) + int'(done);
    end
    check("empty_play_quiet", extra, 0);

    // Table: record (full or stopped), then play back
    for (int v = 0; v < 5; v++) begin
      push_seq(1'b1, vecs[v].exp_len);
      record_req = 1'b1; step; record_req = 1'b0;
      check("rec_enter", int'(recording), 1);
      t = 0; nwe = 0;
      if (vecs[v].stop_after != 0) begin
        for (int c = 0; c < 60; c++) begin
          step; t++;
          if (mem_we) begin
            nwe++;
            check("we_spacing", t, 4 * nwe);
          end
          if (done || (nwe == vecs[v].stop_after)) break;
        end
      end
      if (vecs[v].stop_after >= 0) begin
        stop_req = 1'b1; step; stop_req = 1'b0;
      end
      check("rec_done", int'(done), 1);
      check("rec_writes", nwe, vecs[v].exp_len);
      check("rec_recording_low", int'(recording), 0);
      check("rec_len", int'(rec_len), vecs[v].exp_len);
      step;
      check("rec_done_one_cycle", int'(done), 0);

      push_seq(1'b0, vecs[v].exp_len);
      play_req = 1'b1; step; play_req = 1'b0;
      check("play_enter", int'(playing), int'(vecs[v].exp_len != 0));
      t = 0; nre = 0;
      if (vecs[v].exp_len != 0) begin
        for (int c = 0; c < 60; c++) begin
          step; t++;
          if (mem_re) begin
            nre++;
            check("re_spacing", t, 4 * nre);
          end
          if (done) break;
        end
        check("play_done", int'(done), 1);
        check("play_playing_low", int'(playing), 0);
        check("play_reads", nre, vecs[v].exp_len);
        check("play_rec_len", int'(rec_len), vecs[v].exp_len);
      end
      extra = 0;
      for (int c = 0; c < 12; c++) begin
        step;
        extra += int'(mem_re) + int'(done);
      end
      check("post_play_quiet", extra, 0);
      check("sb_empty", sb_q.size(), 0);
    end

    // Priority: stop beats everything in IDLE
    record_req = 1'b1; play_req = 1'b1; stop_req = 1'b1;
    step;
    record_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
    check("prio_all_recording", int'(recording), 0);
    check("prio_all_playing", int'(playing), 0);
    check("prio_all_done", int'(done), 0);

    // Priority: record beats play; play ignored during REC
    record_req = 1'b1; play_req = 1'b1;
    step;
    record_req = 1'b0; play_req = 1'b0;
    check("prio_rp_recording", int'(recording), 1);
    check("prio_rp_playing", int'(playing), 0);
    play_req = 1'b1; step; play_req = 1'b0;
    check("rec_play_ignored_rec", int'(recording), 1);
    check("rec_play_ignored_play", int'(playing), 0);
    stop_req = 1'b1; step; stop_req = 1'b0;
    check("early_stop_done", int'(done), 1);
    check("early_stop_len", int'(rec_len), 0);

    // Reset in the middle of playback
    push_seq(1'b1, 8);
    record_req = 1'b1; step; record_req = 1'b0;
    for (int c = 0; c < 60; c++) begin
      step;
      if (done) break;
    end
    check("rec2_len", int'(rec_len), 8);
    push_seq(1'b0, 8);
    play_req = 1'b1; step; play_req = 1'b0;
    nre = 0;
    for (int c = 0; c < 60; c++) begin
      step;
      if (mem_re) nre++;
      if (nre == 2) break;
    end
    check("midplay_reads", nre, 2);
    reset_n = 1'b0;
    step;
    sb_q.delete();
    check("midrst_addr", int'(mem_addr), 0);
    check("midrst_re", int'(mem_re), 0);
    check("midrst_rec_len", int'(rec_len), 0);
    check("midrst_playing", int'(playing), 0);
    check("midrst_done", int'(done), 0);
    reset_n = 1'b1;
    step;
    play_req = 1'b1; step; play_req = 1'b0;
    check("post_rst_play_ignored", int'(playing), 0);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      step;
      extra += int'(mem_re) + int'(done);
    end
    check("post_rst_quiet", extra, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
